// File: rtl/l2_port_arbiter_pkg.sv
// Shared widths, FSM states and the latched command payload for the L2 port arbiter.
package l2_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GNT_I,
    ARB_GNT_D,
    ARB_DRAIN
  } arb_state_t;

  typedef struct packed {
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [LINE_W-1:0] wdata;
  } arb_cmd_t;

  // Write wins when a cache raises read and write together.
  function automatic arb_cmd_t make_cmd(input logic              rd,
                                        input logic              wr,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [LINE_W-1:0] data);
    arb_cmd_t c;
    c.read    = rd & ~wr;
    c.write   = wr;
    c.address = addr;
    c.wdata   = data;
    return c;
  endfunction

endpackage

// File: rtl/l2_port_arbiter_rr_pick.sv
// Two-way round-robin pick between I-cache and D-cache requests.
module l2_port_arbiter_rr_pick (
  input  logic i_req,
  input  logic d_req,
  input  logic last_d,
  output logic pick_valid,
  output logic pick_d
);

  // On a tie the side that did not win last time goes next.
  assign pick_valid = i_req | d_req;
  assign pick_d     = d_req & (~i_req | ~last_d);

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one L2 request port between I-cache and D-cache; one transaction in flight,
// command latched at grant, completion steered back to the owning cache only.
module l2_port_arbiter
  import l2_port_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [LINE_W-1:0] l2_rdata,
  output logic [LINE_W-1:0] rdata,
  output logic              grant_d,
  output logic [CNT_W-1:0]  i_grants,
  output logic [CNT_W-1:0]  d_grants
);

  arb_state_t state;
  arb_cmd_t   cmd;
  arb_cmd_t   pick_cmd;
  logic       last_d;
  logic       pick_valid;
  logic       pick_d;

  l2_port_arbiter_rr_pick u_pick (
    .i_req      (i_read | i_write),
    .d_req      (d_read | d_write),
    .last_d     (last_d),
    .pick_valid (pick_valid),
    .pick_d     (pick_d)
  );

  assign pick_cmd = pick_d ? make_cmd(d_read, d_write, d_address, d_wdata)
                           : make_cmd(i_read, i_write, i_address, i_wdata);

  // Completion and read data pass straight through to the owner in the l2_resp cycle.
  assign i_resp     = l2_resp & (state == ARB_GNT_I);
  assign d_resp     = l2_resp & (state == ARB_GNT_D);
  assign rdata      = l2_rdata;
  assign l2_address = cmd.address;
  assign l2_wdata   = cmd.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      cmd      <= '0;
      last_d   <= 1'b0;
      l2_read  <= 1'b0;
      l2_write <= 1'b0;
      grant_d  <= 1'b0;
      i_grants <= '0;
      d_grants <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            cmd      <= pick_cmd;
            last_d   <= pick_d;
            l2_read  <= pick_cmd.read;
            l2_write <= pick_cmd.write;
            grant_d  <= pick_d;
            state    <= pick_d ? ARB_GNT_D : ARB_GNT_I;
          end
        end
        ARB_GNT_I, ARB_GNT_D: begin
          if (l2_resp) begin
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
            grant_d  <= 1'b0;
            if (state == ARB_GNT_D) d_grants <= d_grants + CNT_W'(1);
            else                    i_grants <= i_grants + CNT_W'(1);
            state    <= ARB_DRAIN;
          end
        end
        // One idle cycle so the served cache can drop its request.
        ARB_DRAIN: state <= ARB_IDLE;
        default:   state <= ARB_IDLE;
      endcase
    end
  end

endmodule
